// File: rtl/uart_ctrl_pkg.sv
// rtl/uart_ctrl_pkg.sv - shared types and constants for the UART transmit arbiter
package uart_ctrl_pkg;

    localparam int UART_BYTE_W      = 8;
    localparam int DEF_BUSY_TIMEOUT = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_TRIG,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_DONE
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority select starting at ptr
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] pick,
    output logic [PW-1:0]    idx,
    output logic             any
);

    function automatic int wrap_idx(input int base, input int k);
        return (base + k) % N_REQ;
    endfunction

    // any doubles as the "already found" flag so only the first hit wins
    always_comb begin
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!any && req[wrap_idx(int'(ptr), k)]) begin
                any                          = 1'b1;
                pick[wrap_idx(int'(ptr), k)] = 1'b1;
                idx                          = PW'(wrap_idx(int'(ptr), k));
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one byte UART transmitter among N_REQ producers
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int TRIG_LEN     = 2,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req,
    input  logic [UART_BYTE_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]             grant,
    output logic [N_REQ-1:0]             done,
    output logic                         err,
    output logic [UART_BYTE_W-1:0]       uart_data,
    output logic                         uart_trig,
    input  logic                         uart_busy
);

    localparam int PW  = $clog2(N_REQ);
    localparam int TCW = $clog2(TRIG_LEN + 1);
    localparam int TOW = 7;

    arb_state_t       state, next_state;
    logic [PW-1:0]    ptr, win_idx, pick_idx;
    logic [N_REQ-1:0] pick_onehot;
    logic             pick_any;
    logic [TCW-1:0]   trig_cnt;
    logic [TOW-1:0]   to_cnt;
    logic             trig_active;
    logic             timeout;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .req  (req),
        .ptr  (ptr),
        .pick (pick_onehot),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // trig is registered, so TRIG lasts one cycle longer than the pulse it produces
    assign trig_active = (state == ST_TRIG) && (trig_cnt != TCW'(TRIG_LEN));
    assign timeout     = (state == ST_WAIT_BUSY) && !uart_busy &&
                         (to_cnt >= TOW'(BUSY_TIMEOUT - 1));

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:      if (pick_any && !uart_busy) next_state = ST_LOAD;
            ST_LOAD:      next_state = ST_TRIG;
            ST_TRIG:      if (!trig_active) next_state = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (uart_busy)    next_state = ST_WAIT_DONE;
                else if (timeout) next_state = ST_DONE;
            end
            ST_WAIT_DONE: if (!uart_busy) next_state = ST_DONE;
            ST_DONE:      next_state = ST_IDLE;
            default:      next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            win_idx   <= '0;
            grant     <= '0;
            done      <= '0;
            err       <= 1'b0;
            uart_data <= '0;
            uart_trig <= 1'b0;
            trig_cnt  <= '0;
            to_cnt    <= '0;
        end else begin
            state     <= next_state;
            uart_trig <= trig_active;
            done      <= (next_state == ST_DONE) ? grant : '0;
            err       <= timeout;

            if (state == ST_TRIG) begin
                if (trig_active) trig_cnt <= trig_cnt + 1'b1;
            end else begin
                trig_cnt <= '0;
            end

            if (state != ST_WAIT_BUSY) begin
                to_cnt <= '0;
            end else if (to_cnt != '1) begin
                to_cnt <= to_cnt + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (next_state == ST_LOAD) begin
                        win_idx <= pick_idx;
                        grant   <= pick_onehot;
                    end
                end
                ST_LOAD: uart_data <= req_data[win_idx*UART_BYTE_W +: UART_BYTE_W];
                ST_DONE: begin
                    grant <= '0;
                    ptr   <= (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed bench for uart_tx_arbiter with a modeled UART busy line
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  grant, done;
    logic        err;
    logic [7:0]  uart_data;
    logic        uart_trig;
    logic        uart_busy = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic       stuck  = 1'b0;
    logic       mon_en = 1'b0;
    logic       trig_prev = 1'b0;
    logic [7:0] last_data = 8'h00;
    int         busy_left = 0;
    int         trig_rise_cyc = 0, trig_fall_cyc = 0, busy_fall_cyc = 0;
    int         data_changes = 0;
    logic [7:0] line_q[$];

    uart_tx_arbiter #(
        .N_REQ        (4),
        .TRIG_LEN     (2),
        .BUSY_TIMEOUT (64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .grant     (grant),
        .done      (done),
        .err       (err),
        .uart_data (uart_data),
        .uart_trig (uart_trig),
        .uart_busy (uart_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // UART core stand-in: a trig rise captures the byte and holds busy for 160 cycles
    always @(negedge clk) begin
        trig_prev <= uart_trig;
        last_data <= uart_data;
        if (mon_en && uart_busy && uart_data !== last_data) data_changes <= data_changes + 1;
        if (uart_trig && !trig_prev) begin
            trig_rise_cyc <= cyc;
            if (!stuck) begin
                line_q.push_back(uart_data);
                busy_left <= 160;
                uart_busy <= 1'b1;
            end
        end else if (busy_left > 0) begin
            busy_left <= busy_left - 1;
            if (busy_left == 1) begin
                uart_busy     <= 1'b0;
                busy_fall_cyc <= cyc;
            end
        end
        if (!uart_trig && trig_prev) trig_fall_cyc <= cyc;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(output logic [3:0] d, output int c);
        d = 4'b0000;
        c = 0;
        for (int i = 0; i < 400 && d == 4'b0000; i++) begin
            tick();
            if (done != 4'b0000) begin
                d = done;
                c = cyc;
            end
        end
    endtask

    logic [3:0] d;
    int         dc, bad, base;

    initial begin
        rst_n    = 1'b0;
        req      = 4'b0000;
        req_data = 32'h0;
        repeat (3) tick();
        check("rst_grant", grant, 4'b0000);
        check("rst_done", done, 4'b0000);
        check("rst_err", err, 1'b0);
        check("rst_trig", uart_trig, 1'b0);
        check("rst_data", uart_data, 8'h00);
        check("rst_ptr", dut.ptr, 2'd0);
        rst_n = 1'b1;
        tick();

        // single request on index 1
        req_data[15:8] = 8'h41;
        req            = 4'b0010;
        tick();
        check("t1_grant", grant, 4'b0010);
        check("t1_trig_early", uart_trig, 1'b0);
        tick();
        check("t1_data", uart_data, 8'h41);
        tick();
        check("t1_trig_hi0", uart_trig, 1'b1);
        tick();
        check("t1_trig_hi1", uart_trig, 1'b1);
        tick();
        check("t1_trig_lo", uart_trig, 1'b0);
        wait_done(d, dc);
        req = 4'b0000;
        check("t1_done", d, 4'b0010);
        check("t1_done_lat", dc - busy_fall_cyc, 1);
        tick();
        check("t1_done_pulse", done, 4'b0000);
        check("t1_grant_drop", grant, 4'b0000);
        check("t1_line_n", line_q.size(), 1);
        if (line_q.size() > 0) check("t1_line", line_q[0], 8'h41);

        // all four requesting, rotation from ptr=0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        line_q.delete();
        req_data = 32'h33323130;
        req      = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_done(d, dc);
            check("t2_done", d, 4'b0001 << (k % 4));
            if (k == 4) begin
                req = 4'b0000;
            end else begin
                repeat (5) tick();
                check("t2_gap", trig_rise_cyc - dc, 4);
            end
        end
        tick();
        check("t2_line_n", line_q.size(), 5);
        if (line_q.size() == 5)
            for (int k = 0; k < 5; k++) check("t2_line", line_q[k], 8'h30 + (k % 4));

        // busy never rises: timeout path
        stuck           = 1'b1;
        req_data[23:16] = 8'h5a;
        req             = 4'b0100;
        wait_done(d, dc);
        check("t3_done", d, 4'b0100);
        check("t3_err", err, 1'b1);
        check("t3_wait_len", dc - trig_fall_cyc, 64);
        req = 4'b0000;
        tick();
        check("t3_err_pulse", err, 1'b0);
        check("t3_done_pulse", done, 4'b0000);
        check("t3_ptr", dut.ptr, 2'd3);
        stuck = 1'b0;

        // reset while the frame is on the line
        req_data[7:0] = 8'h11;
        req           = 4'b0001;
        for (int i = 0; i < 50 && !uart_busy; i++) tick();
        repeat (10) tick();
        check("t4_pre_grant", grant, 4'b0001);
        rst_n = 1'b0;
        tick();
        check("t4_grant", grant, 4'b0000);
        check("t4_done", done, 4'b0000);
        check("t4_err", err, 1'b0);
        check("t4_trig", uart_trig, 1'b0);
        check("t4_data", uart_data, 8'h00);
        check("t4_ptr", dut.ptr, 2'd0);
        rst_n = 1'b1;
        bad   = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (grant != 4'b0000) bad++;
            if (!uart_busy) break;
        end
        check("t4_no_grant_busy", bad, 0);
        tick();
        check("t4_grant_after", grant, 4'b0001);
        wait_done(d, dc);
        req = 4'b0000;
        check("t4_done_after", d, 4'b0001);

        // move ptr to 2, then simultaneous requests on 0 and 3
        req_data[15:8] = 8'h22;
        req            = 4'b0010;
        wait_done(d, dc);
        req = 4'b0000;
        tick();
        check("t5_ptr", dut.ptr, 2'd2);
        mon_en          = 1'b1;
        base            = line_q.size();
        req_data[7:0]   = 8'h55;
        req_data[31:24] = 8'haa;
        req             = 4'b1001;
        wait_done(d, dc);
        check("t5_first", d, 4'b1000);
        req = 4'b0001;
        wait_done(d, dc);
        check("t5_second", d, 4'b0001);
        req = 4'b0000;
        tick();
        mon_en = 1'b0;
        check("t5_line_n", line_q.size(), base + 2);
        if (line_q.size() == base + 2) begin
            check("t5_line0", line_q[base], 8'haa);
            check("t5_line1", line_q[base+1], 8'h55);
        end
        check("t5_data_stable", data_changes, 0);
        check("t5_ptr_end", dut.ptr, 2'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one `uart_tx_8bit` transmitter among `N_REQ` byte producers. Each requester holds a byte request until the arbiter sequences it onto the core: latch data, pulse `trig`, then track `busy` through the full frame. The arbiter returns a one-cycle `done` to the owner after each frame. It sits between application logic (status reporters, ASCII generators, debug taps) and the single UART core.

## Interface
- `N_REQ`, 4, number of requesters (2..8).
- `TRIG_LEN`, 2, cycles `uart_trig` is held high per byte (≥1).
- `BUSY_TIMEOUT`, 64, cycles to wait for `uart_busy` to rise after trig before aborting.

- `clk`  in  1  system clock, 16 MHz.
- `rst_n`  in  1  synchronous, active-low reset.
- `req`  in  N_REQ  per-requester byte request, level.
- `req_data`  in  8*N_REQ  byte for requester i at bits [8i+7:8i].
- `grant`  out  N_REQ  one-hot, owner of the core; high from LOAD through DONE.
- `done`  out  N_REQ  one-cycle pulse to the owner when its frame has completed.
- `err`  out  1  one-cycle pulse on busy timeout (same cycle as `done`).
- `uart_data`  out  8  byte to core `data_in`.
- `uart_trig`  out  1  to core `trig` (rising edge starts frame).
- `uart_busy`  in  1  from core `busy`; high while a frame is on the line.

## Operation
- Handshake: the requester raises `req[i]` with `req_data[i]` stable and keeps both until `done[i]`. It drops `req[i]` in the cycle after `done[i]` or keeps it high for back-to-back bytes. Dropping `req` before `done` is illegal; the arbiter ignores it and completes the frame.
- States are IDLE, LOAD, TRIG, WAIT_BUSY, WAIT_DONE, DONE.
- IDLE: if any `req` is set and `uart_busy`=0, go to LOAD.
  - Winner is the first set bit searching from `ptr` upward, with wrap.
  - Winner index is registered; `grant` asserts.
- LOAD: `uart_data` is loaded from the winner's slice. Go to TRIG.
- TRIG: `uart_trig`=1 for `TRIG_LEN` cycles. Go to WAIT_BUSY.
- WAIT_BUSY: wait for `uart_busy`=1, then go to WAIT_DONE.
  - If `BUSY_TIMEOUT` cycles elapse first, go to DONE with `err` pending.
  - If busy already rose during TRIG, leave WAIT_BUSY in its first cycle.
- WAIT_DONE: on `uart_busy`=0, go to DONE.
- DONE: pulse `done[winner]` (plus `err` if timed out). Set `ptr` = winner+1 mod `N_REQ`. Drop `grant`. Go to IDLE.
- `uart_data` holds its last value outside LOAD. It never changes while `uart_busy`=1.
- Fairness: with all requests high, grants rotate 0,1,…,N_REQ-1,0. No requester waits more than N_REQ-1 frames.

## Timing
- Reset values:
  - `grant`=0, `done`=0, `err`=0.
  - `uart_trig`=0, `uart_data`=8'h00.
  - `ptr`=0, state IDLE, timeout counter 0.
- Reset mid-frame: outputs return to reset values on the next edge. The in-flight UART frame is not tracked; after reset, IDLE waits for `uart_busy`=0 before the next grant.
- `req` registered in IDLE at edge T → `grant` high and state LOAD after T. `uart_data` is valid after T+1. `uart_trig` rises after T+2.
- `done` pulse occurs one cycle after the cycle `uart_busy` is sampled low in WAIT_DONE.
- Turnaround from `done` to the next `uart_trig` rise is 4 cycles: DONE, IDLE, LOAD, then TRIG registers `uart_trig`.
- Simultaneous `req` rise and `done` for the same index: the new request competes normally. `ptr` has already advanced past it.
- The timeout counter is 7 bits wide (sized for `BUSY_TIMEOUT` ≤ 127). It clears on entry to WAIT_BUSY and saturates.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package `uart_ctrl_pkg` holds:
  - the state enum (`ST_IDLE`…`ST_DONE`), 3 bits;
  - `UART_BYTE_W`=8;
  - the default `BUSY_TIMEOUT`.
- Sub-module `rr_pick`: combinational round-robin priority select. Inputs are `req[N_REQ]` and `ptr`. Outputs are a one-hot pick and its index, plus `any`. It is instantiated once; the FSM lives in `uart_tx_arbiter`.
- `uart_tx_8bit` is instantiated outside, by the integrating top.

## Test plan
- Single request: `req`=4'b0010, `req_data[15:8]`=8'h41.
  - Response: `grant`=4'b0010; `uart_data`=8'h41 one cycle later; `uart_trig` high 2 cycles.
  - After the modeled busy (160 cycles), `done`=4'b0010 for one cycle.
  - Line decodes to 'A'.
- All four requesting continuously, data 8'h30..8'h33.
  - Grant order: 0,1,2,3,0.
  - Line decodes "01230".
  - 4-cycle gap between `done` and the next trig rise.
- Busy-stuck-low model (busy never asserts) with `req[2]`=1.
  - Exactly 64 cycles in WAIT_BUSY, then `done[2]` and `err` pulse together.
  - `ptr` advances to 3.
- Reset asserted in WAIT_DONE while busy=1.
  - Next cycle: all outputs zero and `ptr`=0.
  - No grant is issued until busy falls.
- `req[0]` and `req[3]` rise in the same cycle with `ptr`=2.
  - `req[3]` is granted first, then `req[0]`.
  - `uart_data` stays constant through each busy window.
